// File: rtl/instr_fetch_pkg.sv
// Shared RV32 fetch constants: reset PC, instruction size and PC word/alignment helpers.
package instr_fetch_pkg;

  localparam logic [31:0] RV32_RESET_PC    = 32'h0000_0000;
  localparam int unsigned RV32_INSTR_BYTES = 4;
  localparam logic [31:0] RV32_NOP         = 32'h0000_0013;
  localparam int unsigned PC_WORD_SHIFT    = 2;
  localparam int unsigned PC_ALIGN_MASK    = 3;

  function automatic logic [31:0] rv32_nop();
    return RV32_NOP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: synchronous FIFO with flush, occupancy count and a head read straight from storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [2*WIDTH-1:0]         push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output logic [2*WIDTH-1:0]         head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      wr_ptr_q;
  logic [CW-1:0]      count_q;
  logic               pop_eff;

  assign pop_eff    = pop & (count_q != '0);
  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop_eff);
    end
  end

  // The fetch credit rule must make this unreachable.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop_eff && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// RV32 instruction fetch: PC, credit-based issue to a 1-cycle RAM, and a queue towards decode.
// Optional FETCH_PERF_EN adds fetch_cnt_o / stall_cnt_o performance counters.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RV32_RESET_PC),
  parameter int unsigned      DEPTH    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [WIDTH-1:0] instr_addr_o,
  input  logic [WIDTH-1:0] instr_data_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  input  logic             instr_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [WIDTH-1:0] fetch_cnt_o,
  output logic [WIDTH-1:0] stall_cnt_o
`endif
);

  localparam int unsigned      CW       = $clog2(DEPTH) + 1;
  localparam logic [CW:0]      DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] ALIGN    = ~WIDTH'(PC_ALIGN_MASK);
  localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(RV32_INSTR_BYTES);

  logic [WIDTH-1:0]   pc_q;
  logic [WIDTH-1:0]   inflight_pc_q;
  logic               inflight_q;
  logic [CW-1:0]      count;
  logic               pop;
  logic               push;
  logic               issue;
  logic [CW:0]        pending;
  logic [2*WIDTH-1:0] head_data;

  assign instr_addr_o = pc_q >> PC_WORD_SHIFT;
  assign pop          = instr_valid_o & instr_ready_i;
  assign push         = inflight_q & ~redirect_i;

  // Entries held plus the word still in the RAM pipe must leave room after this cycle's pop.
  always_comb begin
    pending = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    issue   = ~redirect_i & (pending < DEPTH_C);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC & ALIGN;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_i) begin
      pc_q       <= redirect_pc_i & ALIGN;
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q          <= pc_q + PC_STEP;
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .push_data  ({instr_data_i, inflight_pc_q}),
    .pop        (pop),
    .flush      (redirect_i),
    .count      (count),
    .head_valid (instr_valid_o),
    .head_data  (head_data)
  );

  assign instr_o    = head_data[2*WIDTH-1:WIDTH];
  assign instr_pc_o = head_data[WIDTH-1:0];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      fetch_cnt_o <= fetch_cnt_o + WIDTH'(pop & ~redirect_i);
      stall_cnt_o <= stall_cnt_o + WIDTH'(~instr_valid_o & ~redirect_i);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch against a 1-cycle synchronous RAM model.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] ram_q;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_addr_o  (instr_addr),
    .instr_data_i  (ram_q),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM word at word address a holds 32'h1000_0000 + a.
  always @(posedge clk) ram_q <= 32'h1000_0000 + instr_addr;

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = rdy;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; redirect = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", instr_pc); end
    checks++; if (instr_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", instr_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] p;
    do_reset(1'b1);
    step();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_edge1_valid got=%b want=0", instr_valid); end
    checks++; if (instr_addr !== 32'h1) begin failures++; $display("FAIL stream_edge1_addr got=%h want=1", instr_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      p = 32'(i * 4);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== p || instr !== exp_instr(p)) begin
        failures++;
        $display("FAIL stream_head%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, instr_valid, instr_pc, instr, p, exp_instr(p));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    do_reset(1'b0);
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h1000_0000) begin
        failures++;
        $display("FAIL stall_head%0d got v=%b pc=%h ins=%h want v=1 pc=0 ins=10000000", i, instr_valid, instr_pc, instr);
      end
      checks++;
      if (instr_addr !== 32'h2) begin failures++; $display("FAIL stall_addr%0d got=%h want=2", i, instr_addr); end
      step();
    end
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      p = 32'(i * 4);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== p || instr !== exp_instr(p)) begin
        failures++;
        $display("FAIL stall_resume%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, instr_valid, instr_pc, instr, p, exp_instr(p));
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] p;
    do_reset(1'b0);
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b want=0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_gap got=%b want=0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      p = 32'h40 + 32'(i * 4);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== p || instr !== exp_instr(p)) begin
        failures++;
        $display("FAIL redir_head%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, instr_valid, instr_pc, instr, p, exp_instr(p));
      end
      ready = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    do_reset(1'b1);
    step(); step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_first got=%b want=0", instr_valid); end
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b want=0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b want=0", instr_valid); end
    for (int i = 0; i < 2; i++) begin
      step();
      p = 32'h200 + 32'(i * 4);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== p || instr !== exp_instr(p)) begin
        failures++;
        $display("FAIL b2b_head%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, instr_valid, instr_pc, instr, p, exp_instr(p));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] p;
    do_reset(1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL wrap_flush got=%b want=0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL wrap_gap got=%b want=0", instr_valid); end
    p = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== p || instr !== exp_instr(p)) begin
        failures++;
        $display("FAIL wrap_head%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, instr_valid, instr_pc, instr, p, exp_instr(p));
      end
      p = p + 32'd4;
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset(1'b1);
    step(); step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL midrst_instr got=%h want=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL midrst_pc got=%h want=0", instr_pc); end
    checks++; if (instr_addr !== 32'h0) begin failures++; $display("FAIL midrst_addr got=%h want=0", instr_addr); end
    #1;
    rst = 1'b0;
    step(); step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h1000_0000) begin
      failures++;
      $display("FAIL midrst_restart got v=%b pc=%h ins=%h want v=1 pc=0 ins=10000000", instr_valid, instr_pc, instr);
    end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
